// File: rtl/riscv_hwloop_regs.sv
// Hardware-loop register file: per-loop start/end/counter storage written by the
// ID stage, counter decrements from the loop controller, and a registered CSR read port.
module riscv_hwloop_regs #(
    parameter int N_REGS     = 2,
    parameter int N_REG_BITS = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            hwlp_start_data_i,
    input  logic [31:0]            hwlp_end_data_i,
    input  logic [31:0]            hwlp_cnt_data_i,
    input  logic [2:0]             hwlp_we_i,
    input  logic [N_REG_BITS-1:0]  hwlp_regid_i,
    input  logic                   valid_i,
    input  logic [N_REGS-1:0]      hwlp_dec_cnt_i,
    output logic [N_REGS*32-1:0]   hwlp_start_addr_o,
    output logic [N_REGS*32-1:0]   hwlp_end_addr_o,
    output logic [N_REGS*32-1:0]   hwlp_counter_o,
    output logic [N_REGS-1:0]      hwlp_active_o,
    input  logic                   csr_re_i,
    input  logic [N_REG_BITS+1:0]  csr_addr_i,
    output logic [31:0]            csr_rdata_o,
    output logic                   csr_rvalid_o
);

    logic [31:0] start_q [N_REGS];
    logic [31:0] end_q   [N_REGS];
    logic [31:0] cnt_q   [N_REGS];

    for (genvar k = 0; k < N_REGS; k++) begin : g_loop
        logic sel;
        assign sel = (hwlp_regid_i == N_REG_BITS'(k));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                start_q[k] <= '0;
                end_q[k]   <= '0;
                cnt_q[k]   <= '0;
            end else begin
                // PCs are halfword aligned, so bit0 is never stored
                if (sel && hwlp_we_i[0]) start_q[k] <= {hwlp_start_data_i[31:1], 1'b0};
                if (sel && hwlp_we_i[1]) end_q[k]   <= {hwlp_end_data_i[31:1], 1'b0};
                // A counter write wins over a same-cycle decrement of this loop
                if (sel && hwlp_we_i[2])
                    cnt_q[k] <= hwlp_cnt_data_i;
                else if (hwlp_dec_cnt_i[k] && valid_i && cnt_q[k] != '0)
                    cnt_q[k] <= cnt_q[k] - 32'd1;
            end
        end

        assign hwlp_start_addr_o[32*k +: 32] = start_q[k];
        assign hwlp_end_addr_o[32*k +: 32]   = end_q[k];
        assign hwlp_counter_o[32*k +: 32]    = cnt_q[k];
        assign hwlp_active_o[k]              = (cnt_q[k] != '0);
    end

    logic [N_REG_BITS-1:0] csr_idx;
    logic [1:0]            csr_field;
    logic [31:0]           rd_mux;

    assign csr_idx   = csr_addr_i[N_REG_BITS+1:2];
    assign csr_field = csr_addr_i[1:0];

    always_comb begin
        rd_mux = '0;
        if (int'(csr_idx) < N_REGS) begin
            case (csr_field)
                2'd0:    rd_mux = start_q[csr_idx];
                2'd1:    rd_mux = end_q[csr_idx];
                2'd2:    rd_mux = cnt_q[csr_idx];
                default: rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_rdata_o  <= '0;
            csr_rvalid_o <= 1'b0;
        end else begin
            csr_rvalid_o <= csr_re_i;
            if (csr_re_i) csr_rdata_o <= rd_mux;
        end
    end

endmodule

// File: tb/tb_riscv_hwloop_regs.sv
// Directed and randomized checks of riscv_hwloop_regs against a behavioural
// model of the loop register file kept in the bench.
module tb_riscv_hwloop_regs;

    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   start_d, end_d, cnt_d;
    logic [2:0]    we;
    logic [0:0]    regid;
    logic          valid;
    logic [N-1:0]  dec;
    logic [N*32-1:0] start_o, end_o, cnt_o;
    logic [N-1:0]  active_o;
    logic          csr_re;
    logic [2:0]    csr_addr;
    logic [31:0]   csr_rdata;
    logic          csr_rvalid;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_start [N];
    logic [31:0] m_end   [N];
    logic [31:0] m_cnt   [N];
    logic [31:0] m_rdata;
    logic        m_rvalid;

    always #5 clk = ~clk;

    riscv_hwloop_regs #(.N_REGS(N), .N_REG_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .hwlp_start_data_i(start_d), .hwlp_end_data_i(end_d), .hwlp_cnt_data_i(cnt_d),
        .hwlp_we_i(we), .hwlp_regid_i(regid), .valid_i(valid), .hwlp_dec_cnt_i(dec),
        .hwlp_start_addr_o(start_o), .hwlp_end_addr_o(end_o), .hwlp_counter_o(cnt_o),
        .hwlp_active_o(active_o),
        .csr_re_i(csr_re), .csr_addr_i(csr_addr),
        .csr_rdata_o(csr_rdata), .csr_rvalid_o(csr_rvalid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_start[k] = '0; m_end[k] = '0; m_cnt[k] = '0;
        end
        m_rdata = '0; m_rvalid = 1'b0;
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s_start%0d", tag, k), start_o[32*k +: 32], m_start[k]);
            chk($sformatf("%s_end%0d", tag, k), end_o[32*k +: 32], m_end[k]);
            chk($sformatf("%s_cnt%0d", tag, k), cnt_o[32*k +: 32], m_cnt[k]);
            chk($sformatf("%s_active%0d", tag, k), {31'd0, active_o[k]}, {31'd0, m_cnt[k] != 0});
        end
        chk({tag, "_rvalid"}, {31'd0, csr_rvalid}, {31'd0, m_rvalid});
        chk({tag, "_rdata"}, csr_rdata, m_rdata);
    endtask

    task automatic idle();
        we = '0; regid = '0; valid = 1'b0; dec = '0; csr_re = 1'b0; csr_addr = '0;
        start_d = '0; end_d = '0; cnt_d = '0;
    endtask

    // Model: one clock of the loop register file, computed from the pre-edge state.
    task automatic tick(input string tag);
        logic [31:0] ns [N];
        logic [31:0] ne [N];
        logic [31:0] nc [N];
        logic [31:0] rd;
        int          li;
        int          fld;
        li  = int'(csr_addr[2]);
        fld = int'(csr_addr[1:0]);
        rd  = 32'h0;
        if (li < N) begin
            if (fld == 0) rd = m_start[li];
            else if (fld == 1) rd = m_end[li];
            else if (fld == 2) rd = m_cnt[li];
        end
        for (int k = 0; k < N; k++) begin
            ns[k] = m_start[k]; ne[k] = m_end[k]; nc[k] = m_cnt[k];
            if (int'(regid) == k && we[0]) ns[k] = start_d & ~32'd1;
            if (int'(regid) == k && we[1]) ne[k] = end_d & ~32'd1;
            if (int'(regid) == k && we[2]) nc[k] = cnt_d;
            else if (dec[k] && valid && m_cnt[k] > 0) nc[k] = m_cnt[k] - 1;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            m_start[k] = ns[k]; m_end[k] = ne[k]; m_cnt[k] = nc[k];
        end
        m_rvalid = csr_re;
        if (csr_re) m_rdata = rd;
        check_all(tag);
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 1'b0;
        #12;
        check_all("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all("post_reset");

        // lp.setup on loop 1
        regid = 1; we = 3'b111; start_d = 32'h0000_1003; end_d = 32'h0000_1041; cnt_d = 5;
        tick("setup");
        chk("setup_start1_const", start_o[63:32], 32'h1002);
        chk("setup_end1_const", end_o[63:32], 32'h1040);
        chk("setup_cnt1_const", cnt_o[63:32], 32'd5);
        chk("setup_active_const", {30'd0, active_o}, 32'b10);

        // countdown from 3 on loop 1
        regid = 1; we = 3'b100; cnt_d = 3;
        tick("cnt3");
        for (int i = 0; i < 4; i++) begin
            dec = 2'b10; valid = 1'b1;
            tick("countdown");
            chk($sformatf("countdown_const%0d", i), cnt_o[63:32], (i < 3) ? 32'(2 - i) : 32'd0);
        end
        chk("countdown_inactive", {31'd0, active_o[1]}, 32'd0);
        regid = 1; we = 3'b100; cnt_d = 2;
        tick("cnt2");
        dec = 2'b10; valid = 1'b0;
        tick("dec_unqualified");
        chk("dec_unqualified_const", cnt_o[63:32], 32'd2);

        // write/decrement collision
        regid = 1; we = 3'b100; cnt_d = 4;
        tick("cnt4");
        regid = 0; we = 3'b100; cnt_d = 7; dec = 2'b01; valid = 1'b1;
        tick("collide_same");
        chk("collide_same_const", cnt_o[31:0], 32'd7);
        regid = 0; we = 3'b100; cnt_d = 7; dec = 2'b10; valid = 1'b1;
        tick("collide_other");
        chk("collide_other_l0", cnt_o[31:0], 32'd7);
        chk("collide_other_l1", cnt_o[63:32], 32'd3);

        // CSR read-during-write
        regid = 0; we = 3'b010; end_d = 32'h200;
        tick("end200");
        regid = 0; we = 3'b010; end_d = 32'h300; csr_re = 1'b1; csr_addr = 3'b001;
        tick("csr_rdw");
        chk("csr_rdw_const", csr_rdata, 32'h200);
        csr_re = 1'b1; csr_addr = 3'b001;
        tick("csr_reread");
        chk("csr_reread_const", csr_rdata, 32'h300);
        csr_re = 1'b1; csr_addr = 3'b011;
        tick("csr_field3");
        chk("csr_field3_const", csr_rdata, 32'h0);
        tick("csr_idle");
        chk("csr_idle_rvalid", {31'd0, csr_rvalid}, 32'd0);

        // saturation and max value
        regid = 0; we = 3'b100; cnt_d = 32'hFFFF_FFFF;
        tick("max");
        dec = 2'b01; valid = 1'b1;
        tick("max_dec");
        chk("max_dec_const", cnt_o[31:0], 32'hFFFF_FFFE);
        regid = 0; we = 3'b100; cnt_d = 0;
        tick("zero");
        dec = 2'b01; valid = 1'b1;
        tick("zero_dec");
        chk("zero_dec_const", cnt_o[31:0], 32'd0);
        chk("zero_dec_active", {31'd0, active_o[0]}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            we       = 3'($urandom);
            regid    = 1'($urandom);
            start_d  = $urandom;
            end_d    = $urandom;
            cnt_d    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4));
            dec      = 2'($urandom);
            valid    = 1'($urandom);
            csr_re   = 1'($urandom);
            csr_addr = 3'($urandom);
            tick("rand");
        end

        // asynchronous reset mid-cycle with state programmed
        regid = 0; we = 3'b111; start_d = 32'h40; end_d = 32'h80; cnt_d = 9;
        tick("pre_reset0");
        regid = 1; we = 3'b100; cnt_d = 6; csr_re = 1'b1; csr_addr = 3'b010;
        tick("pre_reset1");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick("after_reset");
        chk("after_reset_rvalid", {31'd0, csr_rvalid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
